// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR vote health monitor.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package tmr_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2
  } chan_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tmr_channel_watch.sv
// One channel's OK/SUSPECT/FAULT tracker with a consecutive-mismatch streak.
// Latency: a valid sample at cycle N is reflected on fault at N+1.
// Backpressure: none; samples are taken whenever valid is high.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   clear           returns the channel to OK with a zero streak (wins over valid)
//   valid, mis      sample strobe and this channel's disagreement with the vote
//   fault           registered: channel is in FAULT
//   fault_nxt       next-cycle value of fault, so the parent can register
//                   aggregate flags without an extra cycle of lag
module tmr_channel_watch
  import tmr_pkg::*;
#(
  parameter int MISMATCH_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic valid,
  input  logic mis,
  output logic fault,
  output logic fault_nxt
);

  localparam int SW = $clog2(MISMATCH_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(MISMATCH_LIMIT);

  chan_state_t   state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;

  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    if (clear) begin
      state_nxt  = OK;
      streak_nxt = '0;
    end else if (valid) begin
      case (state)
        OK: begin
          if (mis) begin
            streak_nxt = SW'(1);
            state_nxt  = (MISMATCH_LIMIT == 1) ? FAULT : SUSPECT;
          end
        end
        SUSPECT: begin
          if (mis) begin
            streak_nxt = streak + SW'(1);
            if (streak_nxt == LIMIT) state_nxt = FAULT;
          end else begin
            streak_nxt = '0;
            state_nxt  = OK;
          end
        end
        FAULT: begin
          // Absorbing: only clear or reset leaves this state.
          streak_nxt = LIMIT;
        end
        default: begin
          state_nxt  = OK;
          streak_nxt = '0;
        end
      endcase
    end
  end

  assign fault_nxt = (state_nxt == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= OK;
      streak <= '0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      fault  <= fault_nxt;
    end
  end

endmodule

// File: rtl/tmr_vote_monitor.sv
// Health monitor downstream of a 3:1 majority voter: per-channel sticky faults and voter cross-check.
// Latency: a valid sample or clear at cycle N is reflected on all outputs at N+1.
// Backpressure: none; samples are taken whenever valid is high, clear wins over valid.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   x0, x1, x2, y_vote  raw channel bits and the voter output under check
//   valid, clear        sample strobe; clear drops flags, streaks and counter
//   fault[2:0]          sticky per-channel fault (bit i <-> xi)
//   any_fault           OR of fault bits
//   double_fault        two or more channels faulty
//   vote_err            sticky: y_vote disagreed with the recomputed majority
//   err_count           saturating count of samples with any mismatch; only
//                       live when TMR_VOTE_MONITOR_ERRCNT_EN is defined,
//                       otherwise tied to zero
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int MISMATCH_LIMIT = 4,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x0,
  input  logic              x1,
  input  logic              x2,
  input  logic              y_vote,
  input  logic              valid,
  input  logic              clear,
  output logic [NUM_CH-1:0] fault,
  output logic              any_fault,
  output logic              double_fault,
  output logic              vote_err,
  output logic [CNT_W-1:0]  err_count
);

  logic              maj;
  logic              vote_bad;
  logic [NUM_CH-1:0] x_vec;
  logic [NUM_CH-1:0] mis;
  logic [NUM_CH-1:0] fault_nxt;

  assign maj      = maj3(x0, x1, x2);
  assign vote_bad = (y_vote != maj);
  assign x_vec    = {x2, x1, x0};
  // Streaks compare against the voter's actual output, not our own majority.
  assign mis      = x_vec ^ {NUM_CH{y_vote}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tmr_channel_watch #(
      .MISMATCH_LIMIT(MISMATCH_LIMIT)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .valid    (valid),
      .mis      (mis[i]),
      .fault    (fault[i]),
      .fault_nxt(fault_nxt[i])
    );
  end

  // Aggregates are built from next-state faults so they land in the same
  // cycle as fault itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      any_fault    <= 1'b0;
      double_fault <= 1'b0;
      vote_err     <= 1'b0;
    end else begin
      any_fault    <= |fault_nxt;
      double_fault <= (fault_nxt[0] & fault_nxt[1]) |
                      (fault_nxt[0] & fault_nxt[2]) |
                      (fault_nxt[1] & fault_nxt[2]);
      if (clear)
        vote_err <= 1'b0;
      else if (valid && vote_bad)
        vote_err <= 1'b1;
    end
  end

`ifdef TMR_VOTE_MONITOR_ERRCNT_EN
  logic sample_err;
  assign sample_err = valid && ((|mis) || vote_bad);

  always_ff @(posedge clk) begin
    if (reset || clear)
      err_count <= '0;
    else if (sample_err && (err_count != {CNT_W{1'b1}}))
      err_count <= err_count + CNT_W'(1);
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_tmr_vote_monitor.sv
module tb_tmr_vote_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       x0 = 1'b0, x1 = 1'b0, x2 = 1'b0;
  logic       y_vote = 1'b0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;

  logic [2:0] fault, fault_s;
  logic       any_fault, double_fault, vote_err;
  logic       any_fault_s, double_fault_s, vote_err_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;

  always #5 clk = ~clk;

  tmr_vote_monitor #(.MISMATCH_LIMIT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .x0(x0), .x1(x1), .x2(x2), .y_vote(y_vote),
    .valid(valid), .clear(clear), .fault(fault), .any_fault(any_fault),
    .double_fault(double_fault), .vote_err(vote_err), .err_count(err_count)
  );

  // Narrow-counter copy on the same stimulus, for the saturation check.
  tmr_vote_monitor #(.MISMATCH_LIMIT(4), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .x0(x0), .x1(x1), .x2(x2), .y_vote(y_vote),
    .valid(valid), .clear(clear), .fault(fault_s), .any_fault(any_fault_s),
    .double_fault(double_fault_s), .vote_err(vote_err_s), .err_count(err_count_s)
  );

  typedef struct {
    logic [2:0] fault;
    logic       any;
    logic       dbl;
    logic       verr;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   total = 0;
  int   bad = 0;
  int   cnt8 = 0;
  int   cnt2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: one expected entry per driven cycle, checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("fault", 32'(fault), 32'(m_e.fault));
      chk("any_fault", 32'(any_fault), 32'(m_e.any));
      chk("double_fault", 32'(double_fault), 32'(m_e.dbl));
      chk("vote_err", 32'(vote_err), 32'(m_e.verr));
      chk("err_count", 32'(err_count), 32'(m_e.cnt));
      chk("err_count_small", 32'(err_count_s), 32'(m_e.cnt_s));
    end
  end

  // One cycle of stimulus with the hand-computed flags expected afterwards.
  task automatic step(input logic [2:0] x, input logic y, input logic v,
                      input logic c, input logic r,
                      input logic [2:0] ef, input logic ev);
    exp_t e;
    logic m;
    logic hit;
    @(negedge clk);
    x0 = x[0]; x1 = x[1]; x2 = x[2];
    y_vote = y; valid = v; clear = c; reset = r;
    m   = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    hit = (x != {3{y}}) || (y != m);
    if (r || c) begin
      cnt8 = 0;
      cnt2 = 0;
    end else if (v && hit) begin
      if (cnt8 != 255) cnt8++;
      if (cnt2 != 3) cnt2++;
    end
    e.fault = ef;
    e.any   = |ef;
    e.dbl   = (ef[0] & ef[1]) | (ef[0] & ef[2]) | (ef[1] & ef[2]);
    e.verr  = ev;
`ifdef TMR_VOTE_MONITOR_ERRCNT_EN
    e.cnt   = 8'(cnt8);
    e.cnt_s = 2'(cnt2);
`else
    e.cnt   = 8'd0;
    e.cnt_s = 2'd0;
`endif
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset
    step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    // All channels agree
    for (int i = 0; i < 10; i++) step(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    // Three mismatches then a match: streak broken, no fault
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    // Four consecutive mismatches on channel 0
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
    // Clear together with a mismatching sample: sample discarded
    step(3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    // Gap of invalid cycles does not break the streak
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) step(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
    // Clear, then channel 1 to fault
    step(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0);
    // Channel 2 to fault: double fault
    for (int i = 0; i < 3; i++) step(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0);
    step(3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0);
    // Broken voter: y_vote=0 with majority 1
    step(3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1);
    step(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b1);
    step(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1);
    // Clear, fault channel 0, then clear with a mismatching sample
    step(3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
    step(3'b110, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    // Build a streak of 3, reset discards it
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    // Six mismatches: fault after the 4th, narrow counter saturates at 3
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b110, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0);
    // Drain
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
